register_file_wb: RTL and testbench
===================================

REGISTER_FILE_WB -- requirements
Module: register_file_wb

Interface
REQ-001 The block SHALL have one clock `clk` and a reset `clr`; reset is synchronous and active-high.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high reset
- enable  in  1  global advance; low freezes all state
- rd_writeback  in  5  write address from writeback stage; 0 = no write
- rdval_writeback  in  32  write data from writeback stage
- mark_valid  in  1  decode issues an instruction that will write mark_rd
- mark_rd  in  5  destination being issued
- ctrl_readRegA  in  5  read address A
- ctrl_readRegB  in  5  read address B
- data_readRegA  out  32  read data A
- data_readRegB  out  32  read data B
- busy_A  out  1  register A has an unretired pending write
- busy_B  out  1  register B has an unretired pending write
- sb_error  out  1  sticky scoreboard over/underflow flag

Function
REQ-003 The block SHALL hold 31 writable 32-bit registers r1..r31; r0 SHALL always read 0 and never be written.
REQ-004 On a rising edge with enable=1 and rd_writeback!=0, register[rd_writeback] SHALL take rdval_writeback; write latency is 1 cycle.
REQ-005 Reads SHALL be combinational: read address 0 -> 0; read address == rd_writeback (nonzero) with enable=1 -> rdval_writeback (write-through bypass); otherwise the stored value.
REQ-006 Each of r1..r31 SHALL have a 2-bit pending counter (0..3) of issued-but-unretired writes.
REQ-007 On an enabled edge, the counter SHALL be incremented when mark_valid=1 and mark_rd targets it, and decremented when rd_writeback targets it; both in the same cycle SHALL leave it unchanged.
REQ-008 mark_valid with mark_rd=0 SHALL be ignored.
REQ-009 An increment at count 3 SHALL hold 3 and set sb_error.
REQ-010 A decrement at count 0 SHALL hold 0 and set sb_error; the register write itself still occurs.
REQ-011 sb_error SHALL remain 1 until reset.
REQ-012 busy_X SHALL be 0 for address 0.
REQ-013 Otherwise busy_X SHALL be 1 when the counter is nonzero, except it SHALL be 0 when the counter is 1 and rd_writeback equals that address with enable=1 (retiring this cycle, data bypassed).
REQ-014 With enable=0, registers, counters and sb_error SHALL hold; reads SHALL return stored values with no bypass; busy SHALL reflect counters only.

Reset
REQ-015 With clr=1 on an edge, all registers, all counters and sb_error SHALL become 0, overriding any simultaneous write, mark or enable.
REQ-016 After reset, data_readRegA/B SHALL be 0, busy_A/B SHALL be 0 and sb_error SHALL be 0.
REQ-017 A reset asserted mid-operation SHALL discard all pending counts; writebacks that arrive later for discarded counts follow REQ-010.

Structure
REQ-018 Constants NUM_REGS=32, DATA_W=32, ADDR_W=5 and CNT_W=2 SHALL live in the shared package processor_params.
REQ-019 The per-register saturating up/down counter with error output SHALL be a sub-module pending_counter, instantiated 31 times.
REQ-020 The register array SHALL be built from the existing 32-bit register primitive with per-entry write enables.

Verification
REQ-021 Reset, then read A=5, B=0 -> both data 0, busy 0, sb_error 0.
REQ-022 Write r7=0xDEADBEEF, read A=7 in the same cycle -> data_readRegA=0xDEADBEEF (bypass); next cycle, with no write, still 0xDEADBEEF.
REQ-023 Write r0=0x12345678 -> reads of r0 stay 0; no counter changes.
REQ-024 Mark r3 twice -> busy_A=1 for A=3; first writeback of r3 -> busy stays 1; second writeback -> busy_A=0 in that cycle; mark+writeback r3 in the same cycle -> count unchanged.
REQ-025 Mark r9 four times -> count holds 3 and sb_error=1; five writebacks of r9 -> fifth leaves count 0; sb_error stays 1 until clr.
REQ-026 enable=0 with rd_writeback=4, data 0xFF and mark_valid=1 -> r4 and counters unchanged and no bypass; clr concurrent with a write -> register stays 0.

Source files
------------

// File: rtl/processor_params.sv
// ---------------------------------------------------------------------------
// processor_params
// Shared constants and small types for the register file and its pending-write
// scoreboard.
//   NUM_REGS : number of architectural registers (r0 is hardwired to zero)
//   DATA_W   : register data width
//   ADDR_W   : register address width
//   CNT_W    : width of each per-register pending-write counter
//   cnt_op_e : the operation a pending counter performs on an enabled edge
// ---------------------------------------------------------------------------
package processor_params;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_INC  = 2'b01,
        CNT_DEC  = 2'b10
    } cnt_op_e;

    // A mark and a retire aimed at the same register in one cycle cancel out,
    // so only a lone increment or a lone decrement moves the counter.
    function automatic cnt_op_e decode_cnt_op(input logic inc, input logic dec);
        cnt_op_e op;
        op = CNT_HOLD;
        if (inc && !dec) begin
            op = CNT_INC;
        end else if (dec && !inc) begin
            op = CNT_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/register32.sv
// ---------------------------------------------------------------------------
// register32
// 32-bit storage register with synchronous clear and a write enable.
//   clk : rising-edge clock
//   clr : synchronous active-high clear, wins over we
//   we  : load d on the next rising edge
//   d   : data in
//   q   : stored value
// ---------------------------------------------------------------------------
module register32
    import processor_params::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file_wb_pending_counter.sv
// ---------------------------------------------------------------------------
// pending_counter
// Saturating up/down counter tracking issued-but-unretired writes to a single
// register.
//   clk       : rising-edge clock
//   clr       : synchronous active-high clear
//   enable    : global advance; low holds the count and suppresses errors
//   inc       : an instruction writing this register was issued
//   dec       : a write to this register retired
//   count     : current number of pending writes
//   err_event : this edge would overflow or underflow the counter
// ---------------------------------------------------------------------------
module pending_counter
    import processor_params::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             err_event
);

    cnt_op_e          op;
    logic [CNT_W-1:0] count_next;

    // Saturate at both ends; the offending edge is reported instead of wrapping
    // so the owner can latch a sticky error.
    always_comb begin
        op         = decode_cnt_op(inc, dec);
        count_next = count;
        err_event  = 1'b0;
        if (enable) begin
            case (op)
                CNT_INC: begin
                    if (count == CNT_MAX) begin
                        err_event = 1'b1;
                    end else begin
                        count_next = count + CNT_W'(1);
                    end
                end
                CNT_DEC: begin
                    if (count == '0) begin
                        err_event = 1'b1;
                    end else begin
                        count_next = count - CNT_W'(1);
                    end
                end
                default: begin
                    count_next = count;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/register_file_wb.sv
// ---------------------------------------------------------------------------
// register_file_wb
// 32 x 32-bit register file (r0 hardwired to zero) with a write-through
// bypass from the writeback stage and a per-register pending-write scoreboard.
//   clk             : rising-edge clock
//   clr             : synchronous active-high reset of registers, counters, error
//   enable          : global advance; low freezes all state and disables bypass
//   rd_writeback    : writeback destination (0 = no write)
//   rdval_writeback : writeback data
//   mark_valid      : decode issues an instruction that will write mark_rd
//   mark_rd         : destination being issued
//   ctrl_readRegA/B : read addresses
//   data_readRegA/B : combinational read data
//   busy_A/B        : read register still has an unretired pending write
//   sb_error        : sticky scoreboard overflow/underflow flag
// ---------------------------------------------------------------------------
module register_file_wb
    import processor_params::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              enable,
    input  logic [ADDR_W-1:0] rd_writeback,
    input  logic [DATA_W-1:0] rdval_writeback,
    input  logic              mark_valid,
    input  logic [ADDR_W-1:0] mark_rd,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    output logic              busy_A,
    output logic              busy_B,
    output logic              sb_error
);

    logic [NUM_REGS-1:0][DATA_W-1:0] reg_q;
    logic [NUM_REGS-1:0][CNT_W-1:0]  pend_cnt;
    logic [NUM_REGS-1:0]             err_event;
    logic                            sb_error_q;

    // r0 has no storage and no counter; these constants keep indexing uniform.
    assign reg_q[0]     = '0;
    assign pend_cnt[0]  = '0;
    assign err_event[0] = 1'b0;

    // Because no entry exists for address 0, writes and marks to r0 fall away
    // naturally without any extra qualification.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        logic hit_wb;
        logic hit_mark;

        assign hit_wb   = (rd_writeback == ADDR_W'(i));
        assign hit_mark = mark_valid && (mark_rd == ADDR_W'(i));

        register32 u_reg (
            .clk (clk),
            .clr (clr),
            .we  (enable && hit_wb),
            .d   (rdval_writeback),
            .q   (reg_q[i])
        );

        pending_counter u_cnt (
            .clk       (clk),
            .clr       (clr),
            .enable    (enable),
            .inc       (hit_mark),
            .dec       (hit_wb),
            .count     (pend_cnt[i]),
            .err_event (err_event[i])
        );
    end

    // Error events are already gated by enable inside each counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            sb_error_q <= 1'b0;
        end else if (|err_event) begin
            sb_error_q <= 1'b1;
        end
    end

    assign sb_error = sb_error_q;

    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic              en,
        input logic [ADDR_W-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] value;
        value = stored;
        if (addr == '0) begin
            value = '0;
        end else if (en && (addr == wb_addr)) begin
            value = wb_data;
        end
        return value;
    endfunction

    // A single outstanding write that retires this very cycle is not busy:
    // its data is already visible through the bypass.
    function automatic logic busy_sel(
        input logic [ADDR_W-1:0] addr,
        input logic              en,
        input logic [ADDR_W-1:0] wb_addr,
        input logic [CNT_W-1:0]  cnt
    );
        logic busy;
        busy = 1'b0;
        if (addr != '0 && cnt != '0) begin
            busy = 1'b1;
            if (cnt == CNT_W'(1) && en && (wb_addr == addr)) begin
                busy = 1'b0;
            end
        end
        return busy;
    endfunction

    always_comb begin
        data_readRegA = read_sel(ctrl_readRegA, enable, rd_writeback,
                                 rdval_writeback, reg_q[ctrl_readRegA]);
        data_readRegB = read_sel(ctrl_readRegB, enable, rd_writeback,
                                 rdval_writeback, reg_q[ctrl_readRegB]);
        busy_A        = busy_sel(ctrl_readRegA, enable, rd_writeback,
                                 pend_cnt[ctrl_readRegA]);
        busy_B        = busy_sel(ctrl_readRegB, enable, rd_writeback,
                                 pend_cnt[ctrl_readRegB]);
    end

endmodule

// File: tb/tb_register_file_wb.sv
// ---------------------------------------------------------------------------
// tb_register_file_wb
// Self-checking bench for register_file_wb: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a behavioural model of the register file and scoreboard.
// ---------------------------------------------------------------------------
module tb_register_file_wb;

    logic        clk = 1'b0;
    logic        clr;
    logic        enable;
    logic [4:0]  rd_writeback;
    logic [31:0] rdval_writeback;
    logic        mark_valid;
    logic [4:0]  mark_rd;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        busy_A;
    logic        busy_B;
    logic        sb_error;

    int          checks = 0;
    int          errors = 0;
    bit          chk_on = 1'b0;

    logic [31:0] m_reg [32];
    int          m_cnt [32];
    bit          m_err;

    always #5 clk = ~clk;

    register_file_wb dut (
        .clk             (clk),
        .clr             (clr),
        .enable          (enable),
        .rd_writeback    (rd_writeback),
        .rdval_writeback (rdval_writeback),
        .mark_valid      (mark_valid),
        .mark_rd         (mark_rd),
        .ctrl_readRegA   (ctrl_readRegA),
        .ctrl_readRegB   (ctrl_readRegB),
        .data_readRegA   (data_readRegA),
        .data_readRegB   (data_readRegB),
        .busy_A          (busy_A),
        .busy_B          (busy_B),
        .sb_error        (sb_error)
    );

    task automatic compare32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural view of a read: r0 is zero, a same-cycle enabled writeback
    // is forwarded, anything else comes from storage.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (enable && a == rd_writeback) return rdval_writeback;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (m_cnt[a] == 0) return 1'b0;
        if (m_cnt[a] == 1 && enable && rd_writeback == a) return 1'b0;
        return 1'b1;
    endfunction

    // Model update on every rising edge, straight from the written rules.
    always @(posedge clk) begin
        logic [31:0] n_reg [32];
        int          n_cnt [32];
        bit          n_err;
        n_reg = m_reg;
        n_cnt = m_cnt;
        n_err = m_err;
        if (clr) begin
            for (int r = 0; r < 32; r++) begin
                n_reg[r] = 32'h0;
                n_cnt[r] = 0;
            end
            n_err = 1'b0;
        end else if (enable) begin
            if (rd_writeback != 5'd0) n_reg[rd_writeback] = rdval_writeback;
            for (int r = 1; r < 32; r++) begin
                bit up;
                bit down;
                up   = mark_valid && (mark_rd == r[4:0]);
                down = (rd_writeback == r[4:0]);
                if (up && !down) begin
                    if (n_cnt[r] == 3) n_err = 1'b1;
                    else n_cnt[r] = n_cnt[r] + 1;
                end else if (down && !up) begin
                    if (n_cnt[r] == 0) n_err = 1'b1;
                    else n_cnt[r] = n_cnt[r] - 1;
                end
            end
        end
        m_reg <= n_reg;
        m_cnt <= n_cnt;
        m_err <= n_err;
    end

    task automatic checkOutput();
        compare32("data_readRegA", data_readRegA, exp_read(ctrl_readRegA));
        compare32("data_readRegB", data_readRegB, exp_read(ctrl_readRegB));
        compare32("busy_A", {31'b0, busy_A}, {31'b0, exp_busy(ctrl_readRegA)});
        compare32("busy_B", {31'b0, busy_B}, {31'b0, exp_busy(ctrl_readRegB)});
        compare32("sb_error", {31'b0, sb_error}, {31'b0, m_err});
    endtask

    always @(negedge clk) begin
        if (chk_on) checkOutput();
    end

    // Drives one cycle of inputs shortly after a rising edge and returns
    // while the outputs are settled and well before the next edge.
    task automatic applyStimulus(input bit en_i, input bit clr_i,
                                 input logic [4:0] wb_i, input logic [31:0] d_i,
                                 input bit mv_i, input logic [4:0] mrd_i,
                                 input logic [4:0] a_i, input logic [4:0] b_i);
        @(posedge clk);
        #1;
        enable          = en_i;
        clr             = clr_i;
        rd_writeback    = wb_i;
        rdval_writeback = d_i;
        mark_valid      = mv_i;
        mark_rd         = mrd_i;
        ctrl_readRegA   = a_i;
        ctrl_readRegB   = b_i;
        #1;
    endtask

    task automatic idle(input logic [4:0] a_i, input logic [4:0] b_i);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, a_i, b_i);
    endtask

    task automatic do_reset();
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    function automatic logic [4:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return 5'(r);
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        enable          = 1'b0;
        clr             = 1'b1;
        rd_writeback    = 5'd0;
        rdval_writeback = 32'h0;
        mark_valid      = 1'b0;
        mark_rd         = 5'd0;
        ctrl_readRegA   = 5'd0;
        ctrl_readRegB   = 5'd0;
        @(posedge clk);
        #1;
        chk_on = 1'b1;

        // Reset state
        idle(5'd5, 5'd0);
        compare32("lit_reset_dataA", data_readRegA, 32'h0);
        compare32("lit_reset_dataB", data_readRegB, 32'h0);
        compare32("lit_reset_busyA", {31'b0, busy_A}, 32'h0);
        compare32("lit_reset_busyB", {31'b0, busy_B}, 32'h0);
        compare32("lit_reset_err", {31'b0, sb_error}, 32'h0);

        // Bypass then stored value; unmarked writeback underflows the scoreboard
        applyStimulus(1'b1, 1'b0, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd7, 5'd0);
        compare32("lit_bypass_r7", data_readRegA, 32'hDEADBEEF);
        idle(5'd7, 5'd0);
        compare32("lit_stored_r7", data_readRegA, 32'hDEADBEEF);
        compare32("lit_underflow_err", {31'b0, sb_error}, 32'h1);

        // r0 is never written
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0);
        compare32("lit_r0_write_cycle", data_readRegA, 32'h0);
        idle(5'd0, 5'd7);
        compare32("lit_r0_after", data_readRegA, 32'h0);

        // Two marks, two retirements, then mark+retire together
        do_reset();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
        compare32("lit_mark1_busy", {31'b0, busy_A}, 32'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
        compare32("lit_mark2_busy", {31'b0, busy_A}, 32'h1);
        applyStimulus(1'b1, 1'b0, 5'd3, 32'hA, 1'b0, 5'd0, 5'd3, 5'd0);
        compare32("lit_retire1_busy", {31'b0, busy_A}, 32'h1);
        applyStimulus(1'b1, 1'b0, 5'd3, 32'hB, 1'b0, 5'd0, 5'd3, 5'd0);
        compare32("lit_retire2_busy", {31'b0, busy_A}, 32'h0);
        compare32("lit_retire2_data", data_readRegA, 32'hB);
        idle(5'd3, 5'd0);
        compare32("lit_retired_busy", {31'b0, busy_A}, 32'h0);
        compare32("lit_retired_data", data_readRegA, 32'hB);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd3, 32'hC, 1'b1, 5'd3, 5'd3, 5'd0);
        idle(5'd3, 5'd0);
        compare32("lit_mark_retire_busy", {31'b0, busy_A}, 32'h1);
        compare32("lit_mark_retire_err", {31'b0, sb_error}, 32'h0);

        // Overflow and underflow on r9; error sticks until clr
        do_reset();
        repeat (4) applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        idle(5'd9, 5'd0);
        compare32("lit_overflow_busy", {31'b0, busy_A}, 32'h1);
        compare32("lit_overflow_err", {31'b0, sb_error}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 5'd9, 32'h900 + 32'(k), 1'b0, 5'd0, 5'd9, 5'd0);
        end
        idle(5'd9, 5'd0);
        compare32("lit_drained_busy", {31'b0, busy_A}, 32'h0);
        compare32("lit_drained_err", {31'b0, sb_error}, 32'h1);
        compare32("lit_drained_data", data_readRegA, 32'h904);
        do_reset();
        idle(5'd9, 5'd0);
        compare32("lit_clr_err", {31'b0, sb_error}, 32'h0);

        // enable low freezes everything; clr beats a concurrent write
        applyStimulus(1'b1, 1'b0, 5'd4, 32'h11, 1'b0, 5'd0, 5'd4, 5'd0);
        applyStimulus(1'b0, 1'b0, 5'd4, 32'hFF, 1'b1, 5'd4, 5'd4, 5'd4);
        compare32("lit_frozen_data", data_readRegA, 32'h11);
        compare32("lit_frozen_busy", {31'b0, busy_A}, 32'h0);
        idle(5'd4, 5'd0);
        compare32("lit_after_freeze_data", data_readRegA, 32'h11);
        compare32("lit_after_freeze_busy", {31'b0, busy_A}, 32'h0);
        applyStimulus(1'b1, 1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 5'd4, 5'd0);
        idle(5'd4, 5'd0);
        compare32("lit_clr_wins", data_readRegA, 32'h0);

        // Randomized traffic over a narrow address set to exercise the counters
        for (int n = 0; n < 800; n++) begin
            applyStimulus(($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 2) == 0) ? pick_addr() : 5'd0,
                          $urandom(),
                          ($urandom_range(0, 1) == 1),
                          pick_addr(),
                          pick_addr(),
                          pick_addr());
        end

        idle(5'd0, 5'd0);
        @(posedge clk);
        #1;
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
